// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: request/response bundle for the shared split adder.
//   master modport: requesters and result consumer (drive operands, rsp_ready).
//   slave  modport: the arbiter/adder (drives readies, rsp_*, busy).
//   req0_* : PC-increment requester     req1_* : branch-target requester
//   rsp_*  : tagged result with valid/ready handshake
//   busy   : adder is not idle
interface adder_share_arb_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ready;

  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter in front of one two-stage split adder.
// A granted request is added as a low half (LO) then a high half (HI) using a
// registered carry, and the tagged result is held in DONE until consumed.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : adder_share_arb_if.slave (requests, response, busy)
//   rsp_ovf    : signed overflow of the result, present only when the
//                ADDSHARE_OVF_EN macro is defined
// Parameters: WIDTH (even operand width), FIRST_PRIO (winner of first tie).
module adder_share_arb #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic CLK,
  input  logic RST_N,
  adder_share_arb_if.slave bus
`ifdef ADDSHARE_OVF_EN
  ,
  output logic rsp_ovf
`endif
);

  localparam int unsigned HALF   = WIDTH / 2;
  localparam int unsigned HALF_C = HALF + 1;
  localparam logic        FIRST_BIT = 1'(FIRST_PRIO);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [HALF-1:0]  lo_q, lo_d;
  logic             c_q, c_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             busy_q, busy_d;
`ifdef ADDSHARE_OVF_EN
  logic             rsp_ovf_q, rsp_ovf_d;
`endif

  logic              grant0_c, grant1_c;
  logic [HALF_C-1:0] lo_add_c, hi_add_c;

  // Round-robin: on a tie the requester that did not win last time goes.
  assign grant0_c = (state_q == IDLE) && bus.req0_valid &&
                    (!bus.req1_valid || last_grant_q);
  assign grant1_c = (state_q == IDLE) && bus.req1_valid &&
                    (!bus.req0_valid || !last_grant_q);

  // Ready is suppressed while reset is asserted so nothing looks accepted.
  assign bus.req0_ready = grant0_c && RST_N;
  assign bus.req1_ready = grant1_c && RST_N;

  // Half adders; the high half folds in the carry registered during LO.
  assign lo_add_c = HALF_C'(a_q[HALF-1:0]) + HALF_C'(b_q[HALF-1:0]);
  assign hi_add_c = HALF_C'(a_q[WIDTH-1:HALF]) + HALF_C'(b_q[WIDTH-1:HALF]) +
                    HALF_C'(c_q);

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    lo_d         = lo_q;
    c_d          = c_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
`ifdef ADDSHARE_OVF_EN
    rsp_ovf_d    = rsp_ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant0_c) begin
          a_d          = bus.req0_a;
          b_d          = bus.req0_b;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = LO;
        end else if (grant1_c) begin
          a_d          = bus.req1_a;
          b_d          = bus.req1_b;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = LO;
        end
      end
      LO: begin
        lo_d    = lo_add_c[HALF-1:0];
        c_d     = lo_add_c[HALF];
        state_d = HI;
      end
      HI: begin
        rsp_sum_d   = {hi_add_c[HALF-1:0], lo_q};
        rsp_cout_d  = hi_add_c[HALF];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
`ifdef ADDSHARE_OVF_EN
        rsp_ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (hi_add_c[HALF-1] != a_q[WIDTH-1]);
`endif
        state_d     = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      last_grant_q <= ~FIRST_BIT;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      lo_q         <= '0;
      c_q          <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ADDSHARE_OVF_EN
      rsp_ovf_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      lo_q         <= lo_d;
      c_q          <= c_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      busy_q       <= busy_d;
`ifdef ADDSHARE_OVF_EN
      rsp_ovf_q    <= rsp_ovf_d;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.busy      = busy_q;
`ifdef ADDSHARE_OVF_EN
  assign rsp_ovf       = rsp_ovf_q;
`endif

endmodule

// File: doc/adder_share_arb.md
Name:
adder_share_arb

Overview:
- Arbitrates one shared, two-stage split 32-bit adder between two requesters in the multi-cycle CPU.
- Requester 0 is the PC-increment path (PC, 4). Requester 1 is the branch-target path (PC+4, offset<<2).
- The adder is split into a low-half and a high-half cycle with a registered carry. This keeps the add off the critical path.
- The block accepts one request, sequences the halves, and returns a tagged result through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must be even; HALF = WIDTH/2.
- FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has operands.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid  in  1  requester 1 has operands.
- req1_a  in  WIDTH  requester 1 operand A.
- req1_b  in  WIDTH  requester 1 operand B.
- req1_ready  out  1  requester 1 accepted this cycle.
- rsp_valid  out  1  result available.
- rsp_id  out  1  requester that owns the result.
- rsp_sum  out  WIDTH  A+B modulo 2^WIDTH.
- rsp_cout  out  1  carry out of the MSB.
- rsp_ready  in  1  consumer takes the result.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low, RST_N. Both are fixed.
- Reset: RST_N low at an edge forces state=IDLE and last_grant=~FIRST_PRIO. It clears rsp_valid, rsp_id, rsp_sum, rsp_cout, busy and the internal operand/carry regs to 0.
- Reset mid-operation: an in-flight add is discarded and no response is issued. reqX_ready is 0 while RST_N is low.
- States: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE, arbitration (combinational):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester != last_grant (round-robin).
  - The granted reqX_ready=1 in the same cycle; the other ready stays 0.
  - reqX_ready is never 1 outside IDLE.
- On a handshake (valid & ready) in IDLE: capture A, B and the id; update last_grant; go to LO.
- LO: compute {c, lo} = A[HALF-1:0] + B[HALF-1:0]; register lo and c; go to HI.
- HI: compute {cout, hi} = A[W-1:HALF] + B[W-1:HALF] + c. Register rsp_sum={hi,lo}, rsp_cout and rsp_id; set rsp_valid=1; go to DONE.
- DONE:
  - rsp_valid, rsp_id, rsp_sum and rsp_cout hold stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid=0 at the next edge; go to IDLE.
  - No new request is accepted in that same cycle.
- Latency: handshake at edge N gives rsp_valid=1 after edge N+2, visible in cycle N+3. Minimum request-to-request period is 4 cycles.
- rsp_sum/rsp_cout keep their last values after rsp_valid drops.
- Requester inputs are ignored outside the IDLE handshake cycle. Changing operands mid-operation has no effect.
- Wrap-around: 0xFFFFFFFF + 1 gives sum 0, cout 1. A low-half carry (e.g. 0x0000FFFF + 1) must propagate through c.
- A requester that drops valid before being granted loses nothing; there is no starvation. With both valid continuously, grants alternate 0,1,0,1.

Optional Feature:
- Macro ADDSHARE_OVF_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), signed overflow = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]).
  - rsp_ovf is registered in HI, held with the other rsp_* outputs, and reset to 0.
- Undefined: no rsp_ovf port and no associated logic. All other behaviour is identical.

Test Plan:
- Reset, then req0 only, A=0x00400000, B=4 -> req0_ready=1 in cycle 0; rsp_valid in cycle 3; rsp_id=0, rsp_sum=0x00400004, rsp_cout=0.
- Carry across halves: req1 A=0x0000FFFF, B=0x00000001 -> rsp_sum=0x00010000, rsp_cout=0, rsp_id=1.
- Wrap: A=0xFFFFFFFF, B=1 -> rsp_sum=0, rsp_cout=1. With ADDSHARE_OVF_EN, A=0x7FFFFFFF, B=1 -> rsp_ovf=1.
- Both valid continuously, rsp_ready tied 1, FIRST_PRIO=0 -> grant order 0,1,0,1; handshakes 4 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, busy=1, both reqX_ready=0; the result transfers on the first rsp_ready=1.
- RST_N low during state HI -> next cycle state IDLE, rsp_valid=0, no response. A subsequent req0 with A=8, B=4 returns 12 with normal latency.
